// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: single-register write and read transactions on open-drain SCL/SDA.
// Optional clock stretching in the q2 phase when I2C_MASTER_CLK_STRETCH_EN is defined.
module i2c_master_ctrl #(
   parameter int unsigned CLK_DIV  = 125,
   parameter logic [6:0]  DEV_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       ack_err,
   output logic       busy,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_i,
   input  logic       sda_i
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RESTART, S_RX_BYTE, S_TX_NACK, S_STOP
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    ph_q, ph_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    idx_q, idx_d;
   logic          rw_q, rw_d;
   logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
   logic [7:0]    tx_q, tx_d, rx_q, rx_d;
   logic          ack_q, ack_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d, ack_err_q, ack_err_d;
   logic          busy_q, busy_d, ready_q, ready_d;
   logic          scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
   logic          stall, q_end, u_end, samp;

`ifdef I2C_MASTER_CLK_STRETCH_EN
   // Target holding SCL low while we have released it freezes the high phase.
   assign stall = (ph_q == 2'd2) && !scl_oe_q && !scl_i;
`else
   logic unused_scl;
   assign unused_scl = scl_i;
   assign stall      = 1'b0;
`endif

   assign q_end = (cnt_q == CW'(CLK_DIV - 1)) && !stall;
   assign u_end = q_end && (ph_q == 2'd3);
   assign samp  = q_end && (ph_q == 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ph_q       <= 2'd0;
         bit_q      <= 3'd0;
         idx_q      <= 2'd0;
         rw_q       <= 1'b0;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         tx_q       <= 8'h00;
         rx_q       <= 8'h00;
         ack_q      <= 1'b0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         ack_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ph_q       <= ph_d;
         bit_q      <= bit_d;
         idx_q      <= idx_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         ack_q      <= ack_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ack_err_q  <= ack_err_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         scl_oe_q   <= scl_oe_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ph_d       = ph_q;
      bit_d      = bit_q;
      idx_d      = idx_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      ack_d      = ack_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ack_err_d  = 1'b0;

      // Quarter-period timebase; wraps to phase 0 at every unit boundary.
      if (state_q != S_IDLE && !stall) begin
         if (q_end) begin
            cnt_d = '0;
            ph_d  = ph_q + 2'd1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && ready_q) begin
               state_d = S_START;
               rw_d    = cmd_rw;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               idx_d   = 2'd0;
            end
         end
         S_START: begin
            if (u_end) begin
               state_d = S_TX_BYTE;
               tx_d    = {DEV_ADDR, 1'b0};
               bit_d   = 3'd0;
            end
         end
         S_TX_BYTE: begin
            if (u_end) begin
               if (bit_q == 3'd7) begin
                  state_d = S_RX_ACK;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = {tx_q[6:0], 1'b0};
               end
            end
         end
         S_RX_ACK: begin
            if (samp) ack_d = sda_i;
            if (u_end) begin
               bit_d = 3'd0;
               if (ack_q) begin
                  state_d   = S_STOP;
                  ack_err_d = 1'b1;
               end else if (idx_q == 2'd0) begin
                  state_d = S_TX_BYTE;
                  tx_d    = addr_q;
                  idx_d   = 2'd1;
               end else if (idx_q == 2'd1) begin
                  state_d = rw_q ? S_RESTART : S_TX_BYTE;
                  tx_d    = wdata_q;
                  idx_d   = 2'd2;
               end else begin
                  state_d = rw_q ? S_RX_BYTE : S_STOP;
               end
            end
         end
         S_RESTART: begin
            if (u_end) begin
               state_d = S_TX_BYTE;
               tx_d    = {DEV_ADDR, 1'b1};
               bit_d   = 3'd0;
            end
         end
         S_RX_BYTE: begin
            if (samp) rx_d = {rx_q[6:0], sda_i};
            if (u_end) begin
               if (bit_q == 3'd7) state_d = S_TX_NACK;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         S_TX_NACK: begin
            if (u_end) begin
               state_d    = S_STOP;
               rd_data_d  = rx_q;
               rd_valid_d = 1'b1;
            end
         end
         S_STOP: begin
            if (u_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);

      // Pad drive follows the upcoming state/phase so it lines up with the phase counters.
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_d)
         S_START: sda_oe_d = ph_d[1];
         S_TX_BYTE, S_RX_ACK, S_RX_BYTE, S_TX_NACK: begin
            scl_oe_d = !ph_d[1];
            sda_oe_d = (state_d == S_TX_BYTE) && !tx_d[7];
         end
         S_RESTART: begin
            scl_oe_d = (ph_d == 2'd0);
            sda_oe_d = ph_d[1];
         end
         S_STOP: begin
            scl_oe_d = (ph_d == 2'd0);
            sda_oe_d = !ph_d[1];
         end
         default: ;
      endcase
   end

   assign cmd_ready = ready_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign ack_err   = ack_err_q;
   assign busy      = busy_q;
   assign scl_oe    = scl_oe_q;
   assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level I2C slave model plus a transaction-level reference model.
module tb_i2c_master_ctrl;

   localparam int unsigned CD   = 4;
   localparam int unsigned UNIT = 4 * CD;
   localparam logic [6:0]  DEV  = 7'h50;
   localparam logic [9:0]  TOK_S = 10'h100;
   localparam logic [9:0]  TOK_P = 10'h101;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic       cmd_ready, rd_valid, ack_err, busy, scl_oe, sda_oe;
   logic [7:0] rd_data;
   logic       scl_i, sda_i;

   logic       s_sda_low = 1'b0;
   logic       s_scl_low = 1'b0;
   int         cfg_nack = -1;
   logic [7:0] cfg_rb = 8'h00;
   bit         cfg_stretch = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   assign scl_i = !(scl_oe || s_scl_low);
   assign sda_i = !(sda_oe || s_sda_low);

   always #5 clk = ~clk;

   i2c_master_ctrl #(.CLK_DIV(CD), .DEV_ADDR(DEV)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rd_data(rd_data), .rd_valid(rd_valid), .ack_err(ack_err), .busy(busy),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
   );

   // Monitor counters and bus-level slave; tokens: byte, START, STOP, 0x200|master-ack.
   int         cyc = 0, busy_cnt = 0, ack_cnt = 0, rv_cnt = 0, rv_cyc = 0, fall_cyc = 0;
   logic [7:0] rv_data = 8'h00;
   logic       p_busy = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
   logic [9:0] tok[$];
   int         bitn = 0, byten = 0, stretch_cnt = 0;
   bit         reading = 1'b0, first = 1'b0, go_read = 1'b0;
   logic [7:0] sh = 8'h00;

   always @(negedge clk) begin
      logic lscl, lsda, ack;
      lscl = scl_i;
      lsda = sda_i;
      cyc++;
      if (busy) busy_cnt++;
      if (ack_err) ack_cnt++;
      if (rd_valid) begin rv_cnt++; rv_cyc = cyc; rv_data = rd_data; end
      if (p_busy && !busy) fall_cyc = cyc;
      p_busy = busy;
      if (stretch_cnt > 0) begin
         stretch_cnt--;
         if (stretch_cnt == 0) s_scl_low = 1'b0;
      end
      if (rst) begin
         bitn = 0; byten = 0; reading = 0; first = 0; go_read = 0;
         s_sda_low = 1'b0; s_scl_low = 1'b0; stretch_cnt = 0;
      end else if (lscl && p_scl && p_sda && !lsda) begin
         tok.push_back(TOK_S);
         bitn = 0; first = 1; reading = 0; go_read = 0; s_sda_low = 1'b0;
      end else if (lscl && p_scl && !p_sda && lsda) begin
         tok.push_back(TOK_P);
         bitn = 0; byten = 0; reading = 0; go_read = 0; s_sda_low = 1'b0;
      end else if (lscl && !p_scl) begin
         if (bitn < 8) begin
            sh = {sh[6:0], lsda};
            bitn++;
            if (bitn == 8) tok.push_back({2'b00, sh});
         end else begin
            if (reading) tok.push_back({2'b10, 7'd0, lsda});
            bitn = 9;
         end
      end else if (!lscl && p_scl) begin
         if (bitn == 8) begin
            if (reading) s_sda_low = 1'b0;
            else begin
               ack       = (byten != cfg_nack);
               s_sda_low = ack;
               go_read   = first && sh[0] && ack;
            end
         end else if (bitn == 9) begin
            bitn = 0; byten++; first = 0;
            if (go_read) begin
               reading = 1; go_read = 0; s_sda_low = !cfg_rb[7];
            end else begin
               reading = 0; s_sda_low = 1'b0;
            end
         end else if (reading && bitn > 0) begin
            s_sda_low = !cfg_rb[3'(7 - bitn)];
         end
         if (cfg_stretch && !reading && byten == 0 && bitn == 3) begin
            s_scl_low = 1'b1; stretch_cnt = 27;
         end
      end
      p_scl = lscl;
      p_sda = lsda;
   end

   // Reference: expected bus tokens and transaction length in 4Q units.
   logic [9:0] exp_q[$];
   function automatic int model(input logic rw, input logic [7:0] a, input logic [7:0] wd,
                                input logic [7:0] rb, input int nk);
      int u;
      u = 1;
      exp_q.delete();
      exp_q.push_back(TOK_S);
      exp_q.push_back({2'b00, DEV, 1'b0}); u += 9;
      if (nk == 0) begin exp_q.push_back(TOK_P); return u + 1; end
      exp_q.push_back({2'b00, a}); u += 9;
      if (nk == 1) begin exp_q.push_back(TOK_P); return u + 1; end
      if (!rw) begin
         exp_q.push_back({2'b00, wd}); u += 9;
         exp_q.push_back(TOK_P);
         return u + 1;
      end
      exp_q.push_back(TOK_S); u += 1;
      exp_q.push_back({2'b00, DEV, 1'b1}); u += 9;
      if (nk == 2) begin exp_q.push_back(TOK_P); return u + 1; end
      exp_q.push_back({2'b00, rb});
      exp_q.push_back(10'h201); u += 9;
      exp_q.push_back(TOK_P);
      return u + 1;
   endfunction

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 5000) begin @(negedge clk); n++; end
      if (busy) begin
         n_cmp++; n_err++;
         $display("FAIL %s timeout: busy still %0b after %0d cycles, required 0", nm, busy, n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_tokens(input string nm, input int t0);
      int got_n, bad;
      got_n = tok.size() - t0;
      bad = -1;
      if (got_n == exp_q.size())
         for (int i = 0; i < got_n; i++) if (bad < 0 && tok[t0 + i] !== exp_q[i]) bad = i;
      n_cmp++;
      if (got_n != exp_q.size()) begin
         n_err++;
         $display("FAIL %s bus tokens: got %0d tokens, required %0d", nm, got_n, exp_q.size());
      end else if (bad >= 0) begin
         n_err++;
         $display("FAIL %s bus token %0d: got %03h, required %03h", nm, bad, tok[t0 + bad], exp_q[bad]);
      end
   endtask

   task automatic run_txn(input logic rw, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] rb, input int nk, input int extra, input string nm);
      int b0, e0, v0, t0, units, n;
      logic [7:0] hold;
      bit exp_rv;
      cfg_nack = nk;
      cfg_rb   = rb;
      units    = model(rw, a, wd, rb, nk);
      exp_rv   = rw && nk < 0;
      hold = rd_data;
      b0 = busy_cnt; e0 = ack_cnt; v0 = rv_cnt; t0 = tok.size();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = wd;
      n = 0;
      while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_rw = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
      wait_idle(nm);
      check_tokens(nm, t0);
      n_cmp++;
      if (busy_cnt - b0 !== units * UNIT + extra) begin
         n_err++;
         $display("FAIL %s busy length: got %0d, required %0d", nm, busy_cnt - b0, units * UNIT + extra);
      end
      n_cmp++;
      if (ack_cnt - e0 !== ((nk >= 0) ? 1 : 0)) begin
         n_err++;
         $display("FAIL %s ack_err pulses: got %0d, required %0d", nm, ack_cnt - e0, (nk >= 0) ? 1 : 0);
      end
      n_cmp++;
      if (rv_cnt - v0 !== (exp_rv ? 1 : 0)) begin
         n_err++;
         $display("FAIL %s rd_valid pulses: got %0d, required %0d", nm, rv_cnt - v0, exp_rv ? 1 : 0);
      end
      if (exp_rv) begin
         n_cmp++;
         if (rv_data !== rb) begin
            n_err++;
            $display("FAIL %s rd_data: got %02h, required %02h", nm, rv_data, rb);
         end
         n_cmp++;
         if (fall_cyc - rv_cyc !== int'(UNIT)) begin
            n_err++;
            $display("FAIL %s rd_valid to busy fall: got %0d, required %0d", nm, fall_cyc - rv_cyc, UNIT);
         end
      end else begin
         n_cmp++;
         if (rd_data !== hold) begin
            n_err++;
            $display("FAIL %s rd_data hold: got %02h, required %02h", nm, rd_data, hold);
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({scl_oe, sda_oe, busy, rd_valid, ack_err} !== 5'b0) begin
         n_err++;
         $display("FAIL reset flags: got %05b, required 00000", {scl_oe, sda_oe, busy, rd_valid, ack_err});
      end
      n_cmp++;
      if (rd_data !== 8'h00) begin
         n_err++;
         $display("FAIL reset rd_data: got %02h, required 00", rd_data);
      end
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset cmd_ready: got %0b, required 1", cmd_ready);
      end
   endtask

   task automatic test_write;
      run_txn(1'b0, 8'h12, 8'hA5, 8'h00, -1, 0, "write");
   endtask

   task automatic test_read;
      run_txn(1'b1, 8'h34, 8'h00, 8'h3C, -1, 0, "read");
   endtask

   task automatic test_nack;
      run_txn(1'b1, 8'h22, 8'h00, 8'h77, 0, 0, "nack_dev");
      run_txn(1'b0, 8'h23, 8'h5A, 8'h00, 1, 0, "nack_reg");
      run_txn(1'b1, 8'h24, 8'h00, 8'h99, 2, 0, "nack_devr");
   endtask

   task automatic test_reset_mid_write;
      int e0, v0;
      cfg_nack = -1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h66; cmd_wdata = 8'h99;
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (100) @(negedge clk);
      e0 = ack_cnt; v0 = rv_cnt;
      #1 rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({scl_oe, sda_oe, busy, cmd_ready} !== 4'b0001) begin
         n_err++;
         $display("FAIL rst_mid scl/sda/busy/ready: got %04b, required 0001", {scl_oe, sda_oe, busy, cmd_ready});
      end
      @(negedge clk); #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ack_cnt != e0 || rv_cnt != v0) begin
         n_err++;
         $display("FAIL rst_mid pulses: got %0d ack_err %0d rd_valid, required 0 0", ack_cnt - e0, rv_cnt - v0);
      end
      run_txn(1'b0, 8'h45, 8'hC3, 8'h00, -1, 0, "after_rst");
   endtask

   task automatic test_back_to_back;
      int b0, t0, n, u;
      logic [9:0] both[$];
      cfg_nack = -1;
      u = model(1'b0, 8'h81, 8'h18, 8'h00, -1);
      both = exp_q;
      u += model(1'b0, 8'h7E, 8'hE7, 8'h00, -1);
      exp_q = {both, exp_q};
      b0 = busy_cnt; t0 = tok.size();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h81; cmd_wdata = 8'h18;
      @(posedge clk); #1;
      cmd_addr = 8'h7E; cmd_wdata = 8'hE7;
      n = 0;
      while (busy && n < 5000) begin @(negedge clk); n++; end
      n = 0;
      while (!busy && n < 10) begin @(negedge clk); n++; end
      n_cmp++;
      if (n !== 1) begin
         n_err++;
         $display("FAIL b2b idle gap: got %0d cycles, required 1", n);
      end
      cmd_valid = 1'b0;
      wait_idle("b2b");
      check_tokens("b2b", t0);
      n_cmp++;
      if (busy_cnt - b0 !== u * UNIT) begin
         n_err++;
         $display("FAIL b2b busy length: got %0d, required %0d", busy_cnt - b0, u * UNIT);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 16; i++) begin
         int r, nk;
         r  = int'($urandom_range(0, 5));
         nk = (r < 3) ? -1 : r - 3;
         run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), nk, 0, "random");
      end
   endtask

`ifdef I2C_MASTER_CLK_STRETCH_EN
   task automatic test_stretch;
      cfg_stretch = 1'b1;
      run_txn(1'b0, 8'h12, 8'hA5, 8'h00, -1, 20, "stretch");
      cfg_stretch = 1'b0;
   endtask
`endif

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_reset_mid_write();
      test_back_to_back();
      test_random();
`ifdef I2C_MASTER_CLK_STRETCH_EN
      test_stretch();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
